// File: rtl/lcg_stream_if.sv
// Valid/ready word stream carrying LCG stimulus words into the stream checker.
interface lcg_stream_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lcg_stream_checker.sv
// Regenerates the LCG stimulus sequence locally, locks onto the received stream
// and counts accepted words and post-lock mismatches.
module lcg_stream_checker #(
  parameter int           W        = 32,
  parameter logic [W-1:0] MULT     = W'(32'h41C64E6D),
  parameter logic [W-1:0] INC      = W'(32'h3039),
  parameter int           LOCK_CNT = 4,
  parameter int           LOSS_CNT = 2,
  parameter int           CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  lcg_stream_if.slave       stream,
  input  logic              seed_load,
  input  logic [W-1:0]      seed,
  input  logic              clear,
  output logic              locked,
  output logic [1:0]        state,
  output logic [W-1:0]      expected,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int LR_W = $clog2(LOSS_CNT + 1);
  localparam logic [MR_W-1:0] LOCK_LAST = MR_W'(LOCK_CNT - 1);
  localparam logic [LR_W-1:0] LOSS_LAST = LR_W'(LOSS_CNT - 1);

  state_t          state_q;
  state_t          state_next;
  logic [MR_W-1:0] match_run;
  logic [LR_W-1:0] miss_run;
  logic            accept;
  logic            match;
  logic [W-1:0]    lcg_in;
  logic [W-1:0]    lcg_out;

  assign accept = stream.in_valid & stream.in_ready;
  assign match  = (stream.in_data == expected);

  // One shared LCG step: seed on load, free-running expected once locked, else the received word.
  assign lcg_in  = seed_load ? seed : ((state_q == LOCKED) ? expected : stream.in_data);
  assign lcg_out = lcg_in * MULT + INC;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    if (seed_load) begin
      state_next = LOCKED;
    end else if (accept) begin
      case (state_q)
        IDLE:    state_next = ACQUIRE;
        ACQUIRE: if (match && (match_run == LOCK_LAST)) state_next = LOCKED;
        LOCKED:  if (!match && (miss_run == LOSS_LAST)) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    locked          = (state_q == LOCKED);
    state           = state_q;
    stream.in_ready = !rst && !seed_load && !clear;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      expected   <= '0;
      match_run  <= '0;
      miss_run   <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (seed_load) begin
        expected <= lcg_out;
        miss_run <= '0;
      end else if (accept) begin
        expected <= lcg_out;
        if (word_count != '1) word_count <= word_count + CNT_W'(1);
        case (state_q)
          IDLE: match_run <= '0;
          ACQUIRE: begin
            if (match) match_run <= match_run + MR_W'(1);
            else       match_run <= '0;
            miss_run <= '0;
          end
          LOCKED: begin
            if (match) begin
              miss_run <= '0;
            end else begin
              err_pulse <= 1'b1;
              miss_run  <= miss_run + LR_W'(1);
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
            end
          end
          default: match_run <= '0;
        endcase
      end
      // Clear only ever coincides with seed_load or an idle stream, never an accept.
      if (clear) begin
        err_count  <= '0;
        word_count <= '0;
        err_pulse  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Self-checking bench for lcg_stream_checker: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural stream model.
module tb_lcg_stream_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 2;
  localparam int S_IDLE = 0;
  localparam int S_ACQ  = 1;
  localparam int S_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        clear = 1'b0;

  logic        locked, err_pulse;
  logic [1:0]  state;
  logic [31:0] expected;
  logic [15:0] err_count, word_count;

  logic        s_locked, s_err_pulse;
  logic [1:0]  s_state;
  logic [31:0] s_expected;
  logic [3:0]  s_err_count, s_word_count;

  int errors = 0;
  int checks = 0;

  int          m_state, m_match, m_miss, m_err, m_words;
  logic [31:0] m_exp;
  bit          m_pulse;

  always #5 clk = ~clk;

  lcg_stream_if #(.W(32)) main_if ();
  lcg_stream_if #(.W(32)) sat_if ();

  assign main_if.in_valid = in_valid;
  assign main_if.in_data  = in_data;
  assign sat_if.in_valid  = in_valid;
  assign sat_if.in_data   = in_data;

  lcg_stream_checker #(.W(32), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stream(main_if), .seed_load(seed_load), .seed(seed),
    .clear(clear), .locked(locked), .state(state), .expected(expected),
    .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
  );

  lcg_stream_checker #(.W(32), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stream(sat_if), .seed_load(seed_load), .seed(seed),
    .clear(clear), .locked(s_locked), .state(s_state), .expected(s_expected),
    .err_pulse(s_err_pulse), .err_count(s_err_count), .word_count(s_word_count)
  );

  function automatic logic [31:0] lcg_ref(logic [31:0] x);
    longint unsigned p;
    p = {32'b0, x} * 64'h41C64E6D + 64'h3039;
    return p[31:0];
  endfunction

  function automatic int clamp(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_exp = '0; m_match = 0; m_miss = 0;
    m_err = 0; m_words = 0; m_pulse = 0;
  endtask

  // Stream rules: hunt for LOCK_CNT successive predictions, then free-run and count misses.
  task automatic model_step(bit v, logic [31:0] d, bit sl, logic [31:0] s, bit clr);
    bit acc;
    acc = v && !sl && !clr;
    m_pulse = 0;
    if (clr) begin
      m_err = 0;
      m_words = 0;
    end
    if (sl) begin
      m_exp = lcg_ref(s);
      m_state = S_LOCK;
      m_miss = 0;
    end else if (acc) begin
      m_words++;
      if (m_state == S_IDLE) begin
        m_match = 0;
        m_exp = lcg_ref(d);
        m_state = S_ACQ;
      end else if (m_state == S_ACQ) begin
        m_match = (d == m_exp) ? m_match + 1 : 0;
        m_exp = lcg_ref(d);
        if (m_match == LOCK_CNT) begin
          m_state = S_LOCK;
          m_miss = 0;
        end
      end else begin
        if (d != m_exp) begin
          m_pulse = 1;
          m_err++;
          m_miss++;
          if (m_miss == LOSS_CNT) m_state = S_IDLE;
        end else begin
          m_miss = 0;
        end
        m_exp = lcg_ref(m_exp);
      end
    end
  endtask

  task automatic checkOutput(string tag);
    checkValue({tag, "_state"}, 32'(state), 32'(m_state));
    checkValue({tag, "_locked"}, 32'(locked), 32'(m_state == S_LOCK));
    checkValue({tag, "_expected"}, expected, m_exp);
    checkValue({tag, "_err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    checkValue({tag, "_err_count"}, 32'(err_count), 32'(clamp(m_err, 65535)));
    checkValue({tag, "_word_count"}, 32'(word_count), 32'(clamp(m_words, 65535)));
    checkValue({tag, "_sat_err_count"}, 32'(s_err_count), 32'(clamp(m_err, 15)));
    checkValue({tag, "_sat_word_count"}, 32'(s_word_count), 32'(clamp(m_words, 15)));
  endtask

  task automatic applyStimulus(bit v, logic [31:0] d, bit sl, logic [31:0] s, bit clr, string tag);
    @(negedge clk);
    rst = 1'b0; in_valid = v; in_data = d; seed_load = sl; seed = s; clear = clr;
    #1;
    checkValue({tag, "_in_ready"}, 32'(main_if.in_ready), 32'(!sl && !clr));
    @(posedge clk);
    #1;
    model_step(v, d, sl, s, clr);
    checkOutput(tag);
  endtask

  task automatic doReset(bit v, logic [31:0] d);
    @(negedge clk);
    rst = 1'b1; in_valid = v; in_data = d; seed_load = 1'b0; clear = 1'b0;
    #1;
    checkValue("rst_in_ready", 32'(main_if.in_ready), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    checkOutput("reset");
  endtask

  task automatic feedWord(logic [31:0] d, string tag);
    applyStimulus(1'b1, d, 1'b0, 32'h0, 1'b0, tag);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          sl;
    logic [31:0] s;
    bit          clr;
    int          exp_state;
    logic [31:0] exp_expected;
    bit          exp_pulse;
    int          exp_err;
    int          exp_words;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] w[0:15];
  logic [31:0] x;
  int          got;

  initial begin
    w[0] = 32'h1234_5678;
    for (int i = 1; i < 16; i++) w[i] = lcg_ref(w[i-1]);

    vecs.push_back('{1, w[0],      0, 0, 0, S_ACQ,  w[1], 0, 0, 1});
    vecs.push_back('{1, w[1],      0, 0, 0, S_ACQ,  w[2], 0, 0, 2});
    vecs.push_back('{1, w[2],      0, 0, 0, S_ACQ,  w[3], 0, 0, 3});
    vecs.push_back('{1, w[3],      0, 0, 0, S_ACQ,  w[4], 0, 0, 4});
    vecs.push_back('{1, w[4],      0, 0, 0, S_LOCK, w[5], 0, 0, 5});
    vecs.push_back('{0, 32'hdead,  0, 0, 0, S_LOCK, w[5], 0, 0, 5});
    vecs.push_back('{1, w[5] ^ 1,  0, 0, 0, S_LOCK, w[6], 1, 1, 6});
    vecs.push_back('{1, w[6],      0, 0, 0, S_LOCK, w[7], 0, 1, 7});
    vecs.push_back('{1, ~w[7],     0, 0, 0, S_LOCK, w[8], 1, 2, 8});
    vecs.push_back('{1, ~w[8],     0, 0, 0, S_IDLE, w[9], 1, 3, 9});
    vecs.push_back('{0, 32'h0,     0, 0, 0, S_IDLE, w[9], 0, 3, 9});
    vecs.push_back('{1, 32'hbeef,  1, 0, 0, S_LOCK, 32'h0000_3039, 0, 3, 9});
    vecs.push_back('{1, 32'h3039,  0, 0, 1, S_LOCK, 32'h0000_3039, 0, 0, 0});

    doReset(1'b1, 32'hffff_0000);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].sl, vecs[i].s, vecs[i].clr, $sformatf("vec%0d", i));
      checkValue($sformatf("vec%0d_tbl_state", i), 32'(state), 32'(vecs[i].exp_state));
      checkValue($sformatf("vec%0d_tbl_expected", i), expected, vecs[i].exp_expected);
      checkValue($sformatf("vec%0d_tbl_pulse", i), 32'(err_pulse), 32'(vecs[i].exp_pulse));
      checkValue($sformatf("vec%0d_tbl_err", i), 32'(err_count), 32'(vecs[i].exp_err));
      checkValue($sformatf("vec%0d_tbl_words", i), 32'(word_count), 32'(vecs[i].exp_words));
    end

    // Known-seed run: seed 0, clear counters, then 100 clean words.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, "seed0");
    checkValue("seed0_expected_const", expected, 32'h0000_3039);
    checkValue("seed0_locked_const", 32'(locked), 32'd1);
    x = 32'h0;
    for (int i = 0; i < 100; i++) begin
      x = lcg_ref(x);
      feedWord(x, "run100");
    end
    checkValue("run100_err_const", 32'(err_count), 32'd0);
    checkValue("run100_words_const", 32'(word_count), 32'd100);

    // Single corrupt word while locked: one-cycle pulse, stays locked.
    for (int i = 1; i <= 6; i++) begin x = lcg_ref(x); feedWord(x, "pre7"); end
    x = lcg_ref(x);
    feedWord(x ^ 32'h1, "bad7");
    checkValue("bad7_pulse_const", 32'(err_pulse), 32'd1);
    checkValue("bad7_err_const", 32'(err_count), 32'd1);
    checkValue("bad7_locked_const", 32'(locked), 32'd1);
    x = lcg_ref(x);
    feedWord(x, "good8");
    checkValue("good8_pulse_const", 32'(err_pulse), 32'd0);
    checkValue("good8_err_const", 32'(err_count), 32'd1);

    // Two garbage words drop lock; five clean words relock.
    feedWord(32'hA5A5_0001, "garb1");
    feedWord(32'hA5A5_0002, "garb2");
    checkValue("garb_err_const", 32'(err_count), 32'd3);
    checkValue("garb_state_const", 32'(state), 32'(S_IDLE));
    x = 32'hCAFE_0000;
    for (int i = 0; i < 5; i++) begin
      feedWord(x, "relock");
      if (i == 3) checkValue("relock_not_yet", 32'(locked), 32'd0);
      x = lcg_ref(x);
    end
    checkValue("relock_locked_const", 32'(locked), 32'd1);

    // Acquire with the second word wrong: no error, run restarts from the bad word.
    doReset(1'b0, 32'h0);
    feedWord(32'h0000_0077, "acq0");
    feedWord(32'h0BAD_0BAD, "acqbad");
    checkValue("acqbad_pulse_const", 32'(err_pulse), 32'd0);
    checkValue("acqbad_state_const", 32'(state), 32'(S_ACQ));
    x = lcg_ref(32'h0BAD_0BAD);
    for (int i = 1; i <= 4; i++) begin
      feedWord(x, "acqre");
      checkValue($sformatf("acqre%0d_state", i), 32'(state), (i == 4) ? 32'(S_LOCK) : 32'(S_ACQ));
      x = lcg_ref(x);
    end
    checkValue("acqre_err_const", 32'(err_count), 32'd0);

    // Saturation on the narrow counter instance with valid gaps.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "satclr");
    got = 0;
    for (int n = 0; n < 200 && got < 20; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        feedWord(m_exp, "satw");
        got++;
      end else begin
        applyStimulus(1'b0, $urandom, 1'b0, 32'h0, 1'b0, "satgap");
      end
    end
    checkValue("sat_got_words", 32'(got), 32'd20);
    checkValue("sat_small_const", 32'(s_word_count), 32'd15);
    checkValue("sat_main_const", 32'(word_count), 32'd20);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "satclr2");
    checkValue("satclr_small_const", 32'(s_word_count), 32'd0);
    applyStimulus(1'b1, m_exp, 1'b0, 32'h0, 1'b1, "clrvalid");
    checkValue("clrvalid_words_const", 32'(word_count), 32'd0);

    // Randomized traffic including seed loads, clears and mid-stream resets.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        doReset($urandom_range(0, 1) == 1, $urandom);
      end else if (r < 5) begin
        applyStimulus($urandom_range(0, 1) == 1, $urandom, 1'b1, $urandom, $urandom_range(0, 1) == 1, "rnd_seed");
      end else if (r < 8) begin
        applyStimulus($urandom_range(0, 1) == 1, m_exp, 1'b0, 32'h0, 1'b1, "rnd_clr");
      end else if (r < 50) begin
        applyStimulus(1'b0, $urandom, 1'b0, 32'h0, 1'b0, "rnd_gap");
      end else if (r < 65) begin
        feedWord($urandom, "rnd_bad");
      end else begin
        feedWord(m_exp, "rnd_good");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
